// File: rtl/isa_host_regs.sv
`default_nettype none
// ============================================================================
// Module   : isa_host_regs
// Purpose  : Avalon-MM register block that issues ISA I/O requests to the
//            bus sequencer, captures read data, tracks busy state, runs a
//            timeout watchdog and latches ISA interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module isa_host_regs #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [7:0]  control_out,
  input  logic        control_reset_n,
  input  logic        data_read_n,
  output logic [15:0] isa_addr,
  output logic [7:0]  isa_wdata,
  input  logic [7:0]  isa_rdata,
  input  logic        irq_in,
  output logic        irq_out
);

  // Watchdog count at which an outstanding request is aborted.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  localparam logic [2:0] A_ADDR   = 3'd0;
  localparam logic [2:0] A_WDATA  = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_RDATA  = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_IRQEN  = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        timeout_set;
  logic        start_rd;

  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        rd_valid_q;
  logic        err_busy_q;
  logic        timeout_q;
  logic        irq_pend_q;
  logic        irq_en_q;
  logic        sync1_q, sync2_q, edge_q;
  logic        irq_out_q;
  logic [31:0] readdata_q, readdata_d;

  logic        wr_addr, wr_wdata, wr_ctrl, wr_status, wr_irqen;
  logic        busy_reject;
  logic        irq_rise;
  logic        unused_wdata;

  assign wr_addr   = avs_write && (avs_address == A_ADDR);
  assign wr_wdata  = avs_write && (avs_address == A_WDATA);
  assign wr_ctrl   = avs_write && (avs_address == A_CTRL);
  assign wr_status = avs_write && (avs_address == A_STATUS);
  assign wr_irqen  = avs_write && (avs_address == A_IRQEN);

  // Writes that would disturb the in-flight ISA cycle are dropped and flagged.
  assign busy_reject = (state_q == ST_BUSY) && (wr_addr || wr_wdata || wr_ctrl);
  assign irq_rise    = sync2_q && !edge_q;
  assign unused_wdata = ^avs_writedata[31:16];

  // State, request word and watchdog registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ctrl_q  <= 2'b00;
      wdog_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      wdog_q  <= wdog_d;
    end
  end

  // Request sequencing: start on a non-zero CTRL write, end on completion
  // or watchdog expiry (completion takes priority over the abort).
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    wdog_d      = wdog_q;
    timeout_set = 1'b0;
    start_rd    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_ctrl && (avs_writedata[1:0] != 2'b00)) begin
          state_d  = ST_BUSY;
          ctrl_d   = avs_writedata[0] ? 2'b01 : 2'b10;
          wdog_d   = 8'd0;
          start_rd = avs_writedata[0];
        end
      end
      ST_BUSY: begin
        if (!control_reset_n) begin
          state_d = ST_IDLE;
          ctrl_d  = 2'b00;
        end else if (wdog_q == WDOG_LAST) begin
          state_d     = ST_IDLE;
          ctrl_d      = 2'b00;
          timeout_set = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ctrl_d  = 2'b00;
      end
    endcase
  end

  // Software-visible registers, status flags (set beats W1C) and IRQ path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      rd_valid_q <= 1'b0;
      err_busy_q <= 1'b0;
      timeout_q  <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_en_q   <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      edge_q     <= 1'b0;
      irq_out_q  <= 1'b0;
    end else begin
      if (wr_addr && (state_q == ST_IDLE))  addr_q  <= avs_writedata[15:0];
      if (wr_wdata && (state_q == ST_IDLE)) wdata_q <= avs_writedata[7:0];
      if (wr_irqen)                         irq_en_q <= avs_writedata[0];

      if (!data_read_n) rdata_q <= isa_rdata;

      if (!data_read_n)                           rd_valid_q <= 1'b1;
      else if (start_rd)                          rd_valid_q <= 1'b0;
      else if (wr_status && avs_writedata[1])     rd_valid_q <= 1'b0;

      if (busy_reject)                            err_busy_q <= 1'b1;
      else if (wr_status && avs_writedata[2])     err_busy_q <= 1'b0;

      if (timeout_set)                            timeout_q <= 1'b1;
      else if (wr_status && avs_writedata[3])     timeout_q <= 1'b0;

      if (irq_rise)                               irq_pend_q <= 1'b1;
      else if (wr_status && avs_writedata[4])     irq_pend_q <= 1'b0;

      sync1_q   <= irq_in;
      sync2_q   <= sync1_q;
      edge_q    <= sync2_q;
      irq_out_q <= irq_pend_q && irq_en_q;
    end
  end

  // Read mux over pre-edge register state.
  always_comb begin
    readdata_d = 32'h0;
    case (avs_address)
      A_ADDR:   readdata_d[15:0] = addr_q;
      A_WDATA:  readdata_d[7:0]  = wdata_q;
      A_CTRL:   readdata_d[1:0]  = ctrl_q;
      A_RDATA:  readdata_d[7:0]  = rdata_q;
      A_STATUS: readdata_d[4:0]  = {irq_pend_q, timeout_q, err_busy_q,
                                    rd_valid_q, (state_q == ST_BUSY)};
      A_IRQEN:  readdata_d[0]    = irq_en_q;
      default:  readdata_d       = 32'h0;
    endcase
  end

  // Registered Avalon read data, one cycle latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      readdata_q <= 32'h0;
    end else if (avs_read) begin
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign control_out  = {6'b000000, ctrl_q};
  assign isa_addr     = addr_q;
  assign isa_wdata    = wdata_q;
  assign irq_out      = irq_out_q;

endmodule
`default_nettype wire
